// File: rtl/tcl_param.sv
// ---------------------------------------------------------------------------
// tcl_param
//
// Parametrised transaction-layer core. Words enter a shared ingress FIFO and
// are routed by their destination field (top PSEL_W bits) into one of
// NUM_PORTS egress FIFOs. Per-port threshold flow control, almost-full /
// almost-empty flags, sticky error detection and readable pop counters.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   init                : while high, latch thresholds and hold in INIT
//   Umbral_bajo/alto    : almost-empty / almost-full (flow-control) thresholds
//   pushIn, dataInputFIFO : ingress write
//   popOut              : per-port pop request
//   req, idx            : counter read (idx == NUM_PORTS reads the sum)
//   dataOut             : registered popped word, port p at [p*DATA_W +: DATA_W]
//   portEmpty/AlmostEmpty/AlmostFull : egress status
//   inFull              : ingress full
//   idle, errorOut      : FSM in IDLE / ERROR
//   counterOut, counterValid : counter read data, valid one cycle after req
// ---------------------------------------------------------------------------
module tcl_param #(
    parameter int DATA_W    = 12,
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 5,
    localparam int PSEL_W   = $clog2(NUM_PORTS),
    localparam int IDX_W    = $clog2(NUM_PORTS + 1),
    localparam int OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic [OCC_W-1:0]            Umbral_bajo,
    input  logic [OCC_W-1:0]            Umbral_alto,
    input  logic                        pushIn,
    input  logic [DATA_W-1:0]           dataInputFIFO,
    input  logic [NUM_PORTS-1:0]        popOut,
    input  logic                        req,
    input  logic [IDX_W-1:0]            idx,
    output logic [NUM_PORTS*DATA_W-1:0] dataOut,
    output logic [NUM_PORTS-1:0]        portEmpty,
    output logic [NUM_PORTS-1:0]        portAlmostEmpty,
    output logic [NUM_PORTS-1:0]        portAlmostFull,
    output logic                        inFull,
    output logic                        idle,
    output logic                        errorOut,
    output logic [CNT_W-1:0]            counterOut,
    output logic                        counterValid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_SUM  = IDX_W'(NUM_PORTS);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Occupancy update for a FIFO that may gain and lose one entry per cycle.
    function automatic logic [OCC_W-1:0] occ_next(input logic [OCC_W-1:0] occ,
                                                   input logic inc,
                                                   input logic dec);
        case ({inc, dec})
            2'b10:   occ_next = occ + OCC_W'(1'b1);
            2'b01:   occ_next = occ - OCC_W'(1'b1);
            default: occ_next = occ;
        endcase
    endfunction

    state_t state_r, state_s;

    logic [OCC_W-1:0]  lo_r, hi_r;

    logic [DATA_W-1:0] in_mem_r [DEPTH];
    logic [AW-1:0]     in_wr_r, in_rd_r;
    logic [OCC_W-1:0]  in_occ_r;

    logic [DATA_W-1:0] eg_mem_r [NUM_PORTS][DEPTH];
    logic [AW-1:0]     eg_wr_r  [NUM_PORTS];
    logic [AW-1:0]     eg_rd_r  [NUM_PORTS];
    logic [OCC_W-1:0]  eg_occ_r [NUM_PORTS];
    logic [CNT_W-1:0]  cnt_r    [NUM_PORTS];

    logic                 run_s, in_empty_s, any_busy_s;
    logic                 overflow_s, underflow_s, push_ok_s, in_pop_s, dest_ok_s;
    logic [DATA_W-1:0]    head_s;
    logic [PSEL_W-1:0]    dest_s;
    logic [NUM_PORTS-1:0] xfer_s, pop_ok_s;
    logic [CNT_W-1:0]     sum_s, sel_s;

    // Datapath only moves in IDLE/ACTIVE; INIT and ERROR freeze contents.
    assign run_s       = (state_r == ST_IDLE) || (state_r == ST_ACTIVE);
    assign in_empty_s  = (in_occ_r == OCC_ZERO);
    assign inFull      = (in_occ_r == OCC_FULL);
    // A push into a full ingress is dropped even if the head leaves this cycle.
    assign push_ok_s   = run_s && pushIn && !inFull;
    assign overflow_s  = run_s && pushIn && inFull;
    assign pop_ok_s    = run_s ? (popOut & ~portEmpty) : {NUM_PORTS{1'b0}};
    assign underflow_s = run_s && (|(popOut & portEmpty));
    assign any_busy_s  = !in_empty_s || !(&portEmpty);

    // Egress status flags decoded from registered occupancy.
    always_comb begin
        portEmpty       = {NUM_PORTS{1'b0}};
        portAlmostEmpty = {NUM_PORTS{1'b0}};
        portAlmostFull  = {NUM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            portEmpty[p]       = (eg_occ_r[p] == OCC_ZERO);
            portAlmostEmpty[p] = (eg_occ_r[p] <= lo_r);
            portAlmostFull[p]  = (eg_occ_r[p] >= hi_r);
        end
    end

    // Head-of-line routing: the head moves only if its port is below the
    // flow-control threshold and not full; otherwise the whole queue stalls.
    // A destination code with no matching port is discarded so it cannot
    // wedge the queue when NUM_PORTS is not a power of two.
    always_comb begin
        head_s    = in_mem_r[in_rd_r];
        dest_s    = head_s[DATA_W-1 -: PSEL_W];
        dest_ok_s = 1'b0;
        xfer_s    = {NUM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (dest_s == PSEL_W'(p)) begin
                dest_ok_s = 1'b1;
                xfer_s[p] = run_s && !in_empty_s &&
                            (eg_occ_r[p] < hi_r) && (eg_occ_r[p] != OCC_FULL);
            end else begin
                xfer_s[p] = 1'b0;
            end
        end
        in_pop_s = run_s && !in_empty_s && ((|xfer_s) || !dest_ok_s);
    end

    // Counter read mux; the aggregate wraps at CNT_W, out-of-range reads 0.
    always_comb begin
        sum_s = {CNT_W{1'b0}};
        sel_s = {CNT_W{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            sum_s = sum_s + cnt_r[p];
            sel_s = (idx == IDX_W'(p)) ? cnt_r[p] : sel_s;
        end
        sel_s = (idx == IDX_SUM) ? sum_s : sel_s;
    end

    // Next-state logic; init overrides everything except RESET.
    always_comb begin
        state_s = state_r;
        if (init && (state_r != ST_RESET)) begin
            state_s = ST_INIT;
        end else begin
            case (state_r)
                ST_RESET:  state_s = ST_INIT;
                ST_INIT:   state_s = ST_IDLE;
                ST_IDLE: begin
                    if (overflow_s || underflow_s) state_s = ST_ERROR;
                    else if (any_busy_s)           state_s = ST_ACTIVE;
                    else                           state_s = ST_IDLE;
                end
                ST_ACTIVE: begin
                    if (overflow_s || underflow_s) state_s = ST_ERROR;
                    else if (!any_busy_s)          state_s = ST_IDLE;
                    else                           state_s = ST_ACTIVE;
                end
                ST_ERROR:  state_s = ST_ERROR;
                default:   state_s = ST_RESET;
            endcase
        end
    end

    // State register and registered state decodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_RESET;
            idle     <= 1'b0;
            errorOut <= 1'b0;
        end else begin
            state_r  <= state_s;
            idle     <= (state_s == ST_IDLE);
            errorOut <= (state_s == ST_ERROR);
        end
    end

    // Threshold registers, loaded while init is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= OCC_FULL;
            lo_r <= OCC_ZERO;
        end else if (init && (state_r != ST_RESET)) begin
            hi_r <= Umbral_alto;
            lo_r <= Umbral_bajo;
        end
    end

    // Counter read port: one-cycle valid pulse per sampled request.
    always_ff @(posedge clk) begin
        if (reset) begin
            counterValid <= 1'b0;
            counterOut   <= {CNT_W{1'b0}};
        end else if (req && (state_r != ST_RESET) && (state_r != ST_INIT)) begin
            counterValid <= 1'b1;
            counterOut   <= sel_s;
        end else begin
            counterValid <= 1'b0;
            counterOut   <= {CNT_W{1'b0}};
        end
    end

    // Ingress pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_wr_r  <= {AW{1'b0}};
            in_rd_r  <= {AW{1'b0}};
            in_occ_r <= OCC_ZERO;
        end else begin
            if (push_ok_s) in_wr_r <= in_wr_r + AW'(1'b1);
            if (in_pop_s)  in_rd_r <= in_rd_r + AW'(1'b1);
            in_occ_r <= occ_next(in_occ_r, push_ok_s, in_pop_s);
        end
    end

    // Ingress storage (contents need no reset; pointers qualify them).
    always_ff @(posedge clk) begin
        if (push_ok_s) in_mem_r[in_wr_r] <= dataInputFIFO;
    end

    // Egress pointers, occupancy, pop counters and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut <= {(NUM_PORTS*DATA_W){1'b0}};
            for (int p = 0; p < NUM_PORTS; p++) begin
                eg_wr_r[p]  <= {AW{1'b0}};
                eg_rd_r[p]  <= {AW{1'b0}};
                eg_occ_r[p] <= OCC_ZERO;
                cnt_r[p]    <= {CNT_W{1'b0}};
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (xfer_s[p]) eg_wr_r[p] <= eg_wr_r[p] + AW'(1'b1);
                if (pop_ok_s[p]) begin
                    dataOut[p*DATA_W +: DATA_W] <= eg_mem_r[p][eg_rd_r[p]];
                    eg_rd_r[p] <= eg_rd_r[p] + AW'(1'b1);
                    cnt_r[p]   <= cnt_r[p] + CNT_W'(1'b1);
                end
                eg_occ_r[p] <= occ_next(eg_occ_r[p], xfer_s[p], pop_ok_s[p]);
            end
        end
    end

    // Egress storage.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (xfer_s[p]) eg_mem_r[p][eg_wr_r[p]] <= head_s;
        end
    end

endmodule

// File: tb/tb_tcl_param.sv
// ---------------------------------------------------------------------------
// tb_tcl_param: self-checking bench for tcl_param (default parameters).
// Per-port reference queues follow every accepted word; each pop moves the
// expected word onto a scoreboard that is compared against dataOut after the
// clock edge. Counter reads are driven from a vector table.
// ---------------------------------------------------------------------------
module tb_tcl_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b0;
    logic [2:0]  Umbral_bajo = 3'd0;
    logic [2:0]  Umbral_alto = 3'd4;
    logic        pushIn = 1'b0;
    logic [11:0] dataInputFIFO = 12'h000;
    logic [3:0]  popOut = 4'h0;
    logic        req = 1'b0;
    logic [2:0]  idx = 3'd0;
    logic [47:0] dataOut;
    logic [3:0]  portEmpty, portAlmostEmpty, portAlmostFull;
    logic        inFull, idle, errorOut, counterValid;
    logic [4:0]  counterOut;

    tcl_param dut (
        .clk(clk), .reset(reset), .init(init),
        .Umbral_bajo(Umbral_bajo), .Umbral_alto(Umbral_alto),
        .pushIn(pushIn), .dataInputFIFO(dataInputFIFO),
        .popOut(popOut), .req(req), .idx(idx),
        .dataOut(dataOut), .portEmpty(portEmpty),
        .portAlmostEmpty(portAlmostEmpty), .portAlmostFull(portAlmostFull),
        .inFull(inFull), .idle(idle), .errorOut(errorOut),
        .counterOut(counterOut), .counterValid(counterValid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  port;
        logic [11:0] word;
    } sb_t;

    typedef struct {
        logic [2:0] idx;
        logic [4:0] expv;
    } cvec_t;

    logic [11:0] model_q [4][$];
    sb_t         sb_q [$];
    logic [11:0] last_out [4];
    cvec_t       ctab [7];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus; expected pops go to the scoreboard and are
    // checked once the edge has produced them.
    task automatic cycle(input logic do_push, input logic [11:0] w,
                         input logic [3:0] pm, input logic track);
        sb_t e;
        pushIn = do_push;
        dataInputFIFO = w;
        popOut = pm;
        if (do_push && track) model_q[w[11:10]].push_back(w);
        for (int p = 0; p < 4; p++) begin
            if (pm[p] && model_q[p].size() > 0) begin
                e.port = 2'(p);
                e.word = model_q[p].pop_front();
                last_out[p] = e.word;
                sb_q.push_back(e);
            end
        end
        tick();
        pushIn = 1'b0;
        popOut = 4'h0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("dout_p%0d", e.port), 48'(dataOut[e.port*12 +: 12]), 48'(e.word));
        end
    endtask

    task automatic do_init(input logic [2:0] lo, input logic [2:0] hi);
        init = 1'b1;
        Umbral_bajo = lo;
        Umbral_alto = hi;
        tick();
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (idle !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        chk(nm, 48'(idle), 48'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ctab[0] = '{3'd0, 5'd1};
        ctab[1] = '{3'd1, 5'd0};
        ctab[2] = '{3'd2, 5'd0};
        ctab[3] = '{3'd3, 5'd2};
        ctab[4] = '{3'd4, 5'd3};
        ctab[5] = '{3'd5, 5'd0};
        ctab[6] = '{3'd7, 5'd0};
        for (int p = 0; p < 4; p++) last_out[p] = 12'h000;

        // Reset values
        tick();
        tick();
        chk("rst_dout", dataOut, 48'h0);
        chk("rst_empty", 48'(portEmpty), 48'hF);
        chk("rst_aempty", 48'(portAlmostEmpty), 48'hF);
        chk("rst_afull", 48'(portAlmostFull), 48'h0);
        chk("rst_flags", 48'({inFull, idle, errorOut, counterValid}), 48'h0);
        reset = 1'b0;
        tick();
        do_init(3'd1, 3'd3);
        chk("init_idle", 48'(idle), 48'd1);

        // Test 1: one word per port, 2-cycle ingress-to-egress latency
        cycle(1'b1, 12'h005, 4'h0, 1'b1);
        chk("lat_t1", 48'(portEmpty[0]), 48'd1);
        cycle(1'b1, 12'h405, 4'h0, 1'b1);
        chk("lat_t2", 48'(portEmpty[0]), 48'd0);
        cycle(1'b1, 12'h805, 4'h0, 1'b1);
        cycle(1'b1, 12'hC05, 4'h0, 1'b1);
        tick();
        chk("t1_empty", 48'(portEmpty), 48'h0);
        chk("t1_aempty", 48'(portAlmostEmpty), 48'hF);
        chk("t1_afull", 48'(portAlmostFull), 48'h0);
        chk("t1_busy", 48'(idle), 48'd0);
        cycle(1'b0, 12'h000, 4'hF, 1'b1);
        wait_idle("t1_idle");
        chk("t1_drained", 48'(portEmpty), 48'hF);

        // Test 2: flow control at alto=3, head-of-line stall
        for (int i = 1; i <= 5; i++) cycle(1'b1, 12'h400 | 12'(i * 17), 4'h0, 1'b1);
        tick();
        chk("t2_afull", 48'(portAlmostFull[1]), 48'd1);
        chk("t2_nfull", 48'(inFull), 48'd0);
        cycle(1'b1, 12'h466, 4'h0, 1'b1);
        chk("t2_in3", 48'(inFull), 48'd0);
        cycle(1'b1, 12'h477, 4'h0, 1'b1);
        chk("t2_in4", 48'(inFull), 48'd1);
        cycle(1'b0, 12'h000, 4'h2, 1'b1);
        chk("t2_pop_af", 48'(portAlmostFull[1]), 48'd0);
        chk("t2_pop_full", 48'(inFull), 48'd1);
        tick();
        chk("t2_refill_af", 48'(portAlmostFull[1]), 48'd1);
        chk("t2_refill_in", 48'(inFull), 48'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 12'h000, 4'h2, 1'b1);
        wait_idle("t2_idle");

        // Test 6: transfer-in and pop together on port 0 at occupancy 2
        cycle(1'b1, 12'h001, 4'h0, 1'b1);
        cycle(1'b1, 12'h002, 4'h0, 1'b1);
        cycle(1'b1, 12'h003, 4'h0, 1'b1);
        chk("t6_occ2", 48'({portAlmostFull[0], portAlmostEmpty[0], portEmpty[0]}), 48'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(i < 3, 12'h004 + 12'(i), 4'h1, 1'b1);
            chk($sformatf("t6_steady%0d", i),
                48'({portAlmostFull[0], portAlmostEmpty[0], portEmpty[0]}), 48'h0);
        end
        cycle(1'b0, 12'h000, 4'h1, 1'b1);
        cycle(1'b0, 12'h000, 4'h1, 1'b1);
        wait_idle("t6_idle");

        // Test 4: underflow on empty port 2 while ACTIVE
        cycle(1'b1, 12'h0AA, 4'h0, 1'b1);
        tick();
        cycle(1'b0, 12'h000, 4'h4, 1'b1);
        chk("t4_error", 48'(errorOut), 48'd1);
        chk("t4_dout2", 48'(dataOut[24 +: 12]), 48'(last_out[2]));
        req = 1'b1;
        idx = 3'd2;
        tick();
        req = 1'b0;
        chk("t4_cvalid", 48'(counterValid), 48'd1);
        chk("t4_cnt2", 48'(counterOut), 48'd1);
        chk("t4_sticky", 48'(errorOut), 48'd1);

        // Test 3: overflow with every port blocked (alto=0)
        do_init(3'd1, 3'd0);
        chk("t3_init_clr", 48'(errorOut), 48'd0);
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 12'h4A0 + 12'(i), 4'h0, 1'b1);
            chk($sformatf("t3_full%0d", i), 48'(inFull), 48'(i == 4));
        end
        chk("t3_noerr", 48'(errorOut), 48'd0);
        cycle(1'b1, 12'h4A5, 4'h0, 1'b0);
        chk("t3_error", 48'(errorOut), 48'd1);
        tick();
        tick();
        chk("t3_sticky", 48'({errorOut, inFull}), 48'h3);
        do_init(3'd1, 3'd3);
        chk("t3_exit", 48'({errorOut, idle}), 48'h1);
        tick();
        chk("t3_active", 48'(idle), 48'd0);
        tick();
        tick();
        cycle(1'b0, 12'h000, 4'h3, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 12'h000, 4'h2, 1'b1);
        wait_idle("t3_idle");

        // Reset while a word sits in the ingress FIFO
        cycle(1'b1, 12'h8EE, 4'h0, 1'b0);
        reset = 1'b1;
        tick();
        chk("mr_state", 48'({idle, errorOut, inFull, portEmpty}), 48'h0F);
        chk("mr_dout", dataOut, 48'h0);
        reset = 1'b0;
        req = 1'b1;
        idx = 3'd4;
        tick();
        tick();
        chk("mr_cvalid_init", 48'(counterValid), 48'd0);
        req = 1'b0;
        do_init(3'd1, 3'd3);
        tick();
        tick();
        chk("mr_nopartial", 48'({idle, portEmpty}), 48'h1F);

        // Test 5: counters, wrap and aggregate
        for (int i = 0; i < 35; i++)
            cycle(i < 33, 12'(i), (i >= 2) ? 4'h1 : 4'h0, 1'b1);
        cycle(1'b1, 12'hC01, 4'h0, 1'b1);
        cycle(1'b1, 12'hC02, 4'h0, 1'b1);
        tick();
        cycle(1'b0, 12'h000, 4'h8, 1'b1);
        cycle(1'b0, 12'h000, 4'h8, 1'b1);
        for (int i = 0; i < 7; i++) begin
            req = 1'b1;
            idx = ctab[i].idx;
            tick();
            chk($sformatf("cnt_valid_idx%0d", ctab[i].idx), 48'(counterValid), 48'd1);
            chk($sformatf("cnt_idx%0d", ctab[i].idx), 48'(counterOut), 48'(ctab[i].expv));
        end
        req = 1'b0;
        tick();
        chk("cnt_pulse", 48'(counterValid), 48'd0);

        // Read sampled with a pop on the same edge sees the pre-pop count
        cycle(1'b1, 12'hC03, 4'h0, 1'b1);
        tick();
        req = 1'b1;
        idx = 3'd3;
        cycle(1'b0, 12'h000, 4'h8, 1'b1);
        chk("cnt_prepop", 48'({counterValid, counterOut}), 48'({1'b1, 5'd2}));
        tick();
        chk("cnt_postpop", 48'(counterOut), 48'd3);
        idx = 3'd4;
        tick();
        chk("cnt_sum", 48'(counterOut), 48'd4);
        req = 1'b0;
        tick();
        chk("cnt_end", 48'(counterValid), 48'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
